// File: rtl/gpio_in_pkg.sv
// Shared types and default sizes for the GPIO input conditioning stage.
package gpio_in_pkg;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } db_state_t;

  localparam int NBITS_DEF   = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int PRESC_W_DEF = 16;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: synchroniser, debounce FSM with tick-driven counter, edge pulses.
// Latency SYNC_STAGES+1 cycles in bypass, plus (db_limit+1) ticks when filtering; no backpressure.
module gpio_debounce_bit
  import gpio_in_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pad_din,
  input  logic             db_en,
  input  logic             tick,
  input  logic [CNT_W-1:0] db_limit,
  output logic             pin_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pad_din};
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    if (!db_en) begin
      lvl_d   = s;
      state_d = DB_STABLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DB_STABLE: begin
          if (s != lvl_q) begin
            state_d = DB_CHECK;
            cnt_d   = '0;
          end
        end
        DB_CHECK: begin
          if (s == lvl_q) begin
            state_d = DB_STABLE;
            cnt_d   = '0;
          end else if (tick) begin
            // >= so a db_limit lowered mid-count still releases on the next tick
            if (cnt_q >= db_limit) begin
              lvl_d   = s;
              state_d = DB_STABLE;
              cnt_d   = '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = DB_STABLE;
      endcase
    end
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign pin_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// Pad input conditioning for grgpio: per-pin sync + debounce sharing one prescaler tick.
// Latency SYNC_STAGES+1 cycles (bypass) plus (db_limit+1) ticks (filtered); no backpressure.
module gpio_in_debounce
  import gpio_in_pkg::*;
#(
  parameter int NBITS       = NBITS_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PRESC_W     = PRESC_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NBITS-1:0]   pad_din,
  input  logic [NBITS-1:0]   db_en,
  input  logic [PRESC_W-1:0] db_presc,
  input  logic [CNT_W-1:0]   db_limit,
  output logic [NBITS-1:0]   gpioi_din,
  output logic [NBITS-1:0]   rise,
  output logic [NBITS-1:0]   fall,
  output logic               changed
);

  logic [PRESC_W-1:0] pc_q, pc_d;
  logic               tick;

  // >= keeps the tick alive if db_presc is lowered below the running count
  assign tick = (pc_q >= db_presc);

  always_comb begin
    pc_d = tick ? '0 : pc_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  for (genvar i = 0; i < NBITS; i++) begin : g_pin
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_bit (
      .clk      (clk),
      .rstn     (rstn),
      .pad_din  (pad_din[i]),
      .db_en    (db_en[i]),
      .tick     (tick),
      .db_limit (db_limit),
      .pin_o    (gpioi_din[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule
